// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control stage: main-control class codes,
// extended ALU operation codes, FSM states and mul/div class predicates.
package alu_ctrl_pkg;

    typedef enum logic [2:0] {
        CLS_R    = 3'b000,
        CLS_I    = 3'b001,
        CLS_LUI  = 3'b010,
        CLS_B    = 3'b011,
        CLS_S    = 3'b100,
        CLS_LOAD = 3'b101,
        CLS_ADD  = 3'b110,
        CLS_RSVD = 3'b111
    } alu_class_e;

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_AND    = 5'd2,
        OP_OR     = 5'd3,
        OP_XOR    = 5'd4,
        OP_SLL    = 5'd5,
        OP_SRL    = 5'd6,
        OP_LUI    = 5'd7,
        OP_BEQ    = 5'd8,
        OP_BNE    = 5'd9,
        OP_SLT    = 5'd10,
        OP_SLTU   = 5'd11,
        OP_SRA    = 5'd12,
        OP_BLT    = 5'd13,
        OP_BGE    = 5'd14,
        OP_BLTU   = 5'd15,
        OP_BGEU   = 5'd16,
        OP_MUL    = 5'd17,
        OP_MULH   = 5'd18,
        OP_MULHSU = 5'd19,
        OP_MULHU  = 5'd20,
        OP_DIV    = 5'd21,
        OP_DIVU   = 5'd22,
        OP_REM    = 5'd23,
        OP_REMU   = 5'd24
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    function automatic logic is_mul_op(alu_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    function automatic logic is_div_op(alu_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/alu_ctrl_stage_decoder.sv
// Combinational decode of {funct7, ALU_Op class, funct3} into an extended
// ALU operation; undecodable combinations yield ADD with illegal set.
module alu_op_decoder
    import alu_ctrl_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [6:0] funct7_i,
    input  logic [2:0] alu_op_i,
    input  logic [2:0] funct3_i,
    output logic [4:0] op_o,
    output logic       illegal_o,
    output logic       is_mul_o,
    output logic       is_div_o
);

    alu_op_e op;
    logic    illegal;

    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the case arms can leave it unassigned and infer a latch.
        op      = OP_ADD;
        illegal = 1'b0;
        case (alu_class_e'(alu_op_i))
            CLS_R: begin
                if (funct7_i == F7_BASE) begin
                    case (funct3_i)
                        3'b000:  op = OP_ADD;
                        3'b001:  op = OP_SLL;
                        3'b010:  op = OP_SLT;
                        3'b011:  op = OP_SLTU;
                        3'b100:  op = OP_XOR;
                        3'b101:  op = OP_SRL;
                        3'b110:  op = OP_OR;
                        default: op = OP_AND;
                    endcase
                end else if (funct7_i == F7_ALT && funct3_i == 3'b000) begin
                    op = OP_SUB;
                end else if (funct7_i == F7_ALT && funct3_i == 3'b101) begin
                    op = OP_SRA;
                end else if (funct7_i == F7_MULDIV && ENABLE_M) begin
                    // M ops are laid out contiguously in funct3 order
                    op = alu_op_e'(5'd17 + {2'b00, funct3_i});
                end else begin
                    illegal = 1'b1;
                end
            end
            CLS_I: begin
                case (funct3_i)
                    3'b000:  op = OP_ADD;
                    3'b010:  op = OP_SLT;
                    3'b011:  op = OP_SLTU;
                    3'b100:  op = OP_XOR;
                    3'b110:  op = OP_OR;
                    3'b111:  op = OP_AND;
                    3'b001: begin
                        if (funct7_i == F7_BASE) op = OP_SLL;
                        else                     illegal = 1'b1;
                    end
                    default: op = funct7_i[5] ? OP_SRA : OP_SRL;
                endcase
            end
            CLS_LUI: op = OP_LUI;
            CLS_B: begin
                case (funct3_i)
                    3'b000:  op = OP_BEQ;
                    3'b001:  op = OP_BNE;
                    3'b100:  op = OP_BLT;
                    3'b101:  op = OP_BGE;
                    3'b110:  op = OP_BLTU;
                    3'b111:  op = OP_BGEU;
                    default: illegal = 1'b1;
                endcase
            end
            CLS_S, CLS_LOAD, CLS_ADD: op = OP_ADD;
            default: illegal = 1'b1;
        endcase
    end

    assign op_o      = op;
    assign illegal_o = illegal;
    assign is_mul_o  = is_mul_op(op);
    assign is_div_o  = is_div_op(op);

endmodule

// File: rtl/alu_ctrl_stage.sv
// Registered ALU control stage: decodes the op, holds multi-cycle MDU ops
// for their latency with a down-counter, and handles stall and flush.
module alu_ctrl_stage
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W       = 5,
    parameter bit ENABLE_M   = 1'b1,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_i,
    input  logic [6:0]      funct7_i,
    input  logic [2:0]      ALU_Op_i,
    input  logic [2:0]      funct3_i,
    input  logic            stall_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            valid_o,
    output logic [OP_W-1:0] ALU_Operation_o,
    output logic            busy_o,
    output logic            mdu_start_o,
    output logic            illegal_o
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    logic [4:0] dec_op;
    logic       dec_illegal;
    logic       dec_is_mul;
    logic       dec_is_div;

    alu_op_decoder #(
        .ENABLE_M (ENABLE_M)
    ) u_decoder (
        .funct7_i  (funct7_i),
        .alu_op_i  (ALU_Op_i),
        .funct3_i  (funct3_i),
        .op_o      (dec_op),
        .illegal_o (dec_illegal),
        .is_mul_o  (dec_is_mul),
        .is_div_o  (dec_is_div)
    );

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              illegal_q, illegal_d;
    logic              mdu_start_q, mdu_start_d;

    assign ready_o = (state_q == ST_IDLE) & ~stall_i & ~flush_i;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        op_d        = op_q;
        illegal_d   = illegal_q;
        mdu_start_d = 1'b0;

        if (flush_i) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            valid_d   = 1'b0;
            illegal_d = 1'b0;
        end else begin
            // The latency counter runs even while downstream is stalled
            if (state_q == ST_BUSY) begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            if (ready_o) begin
                valid_d   = valid_i;
                op_d      = OP_W'(dec_op);
                illegal_d = valid_i & dec_illegal;
                if (valid_i && (dec_is_mul || dec_is_div)) begin
                    mdu_start_d = 1'b1;
                    if (dec_is_div && DIV_CYCLES > 1) begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_W'(DIV_CYCLES - 1);
                    end else if (dec_is_mul && MUL_CYCLES > 1) begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_W'(MUL_CYCLES - 1);
                    end
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge next-state value regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            op_q        <= '0;
            illegal_q   <= 1'b0;
            mdu_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            op_q        <= op_d;
            illegal_q   <= illegal_d;
            mdu_start_q <= mdu_start_d;
        end
    end

    assign valid_o         = valid_q;
    assign ALU_Operation_o = op_q;
    assign busy_o          = (state_q == ST_BUSY);
    assign mdu_start_o     = mdu_start_q;
    assign illegal_o       = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Scoreboard bench for alu_ctrl_stage: expected decodes are queued at the
// accepting edge and compared one step after that edge.
module tb_alu_ctrl_stage;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_i = 1'b0;
    logic [6:0] funct7_i = '0;
    logic [2:0] ALU_Op_i = '0;
    logic [2:0] funct3_i = '0;
    logic       stall_i = 1'b0;
    logic       flush_i = 1'b0;

    logic       ready_o, valid_o, busy_o, mdu_start_o, illegal_o;
    logic [4:0] ALU_Operation_o;
    logic       nom_ready, nom_valid, nom_busy, nom_mdu_start, nom_illegal;
    logic [4:0] nom_op;

    always #5 clk = ~clk;

    alu_ctrl_stage #(.OP_W(5), .ENABLE_M(1'b1), .MUL_CYCLES(2), .DIV_CYCLES(8)) dut (
        .clk(clk), .reset(rst_n), .valid_i(valid_i), .funct7_i(funct7_i),
        .ALU_Op_i(ALU_Op_i), .funct3_i(funct3_i), .stall_i(stall_i), .flush_i(flush_i),
        .ready_o(ready_o), .valid_o(valid_o), .ALU_Operation_o(ALU_Operation_o),
        .busy_o(busy_o), .mdu_start_o(mdu_start_o), .illegal_o(illegal_o)
    );

    alu_ctrl_stage #(.OP_W(5), .ENABLE_M(1'b0), .MUL_CYCLES(2), .DIV_CYCLES(8)) dut_nom (
        .clk(clk), .reset(rst_n), .valid_i(valid_i), .funct7_i(funct7_i),
        .ALU_Op_i(ALU_Op_i), .funct3_i(funct3_i), .stall_i(stall_i), .flush_i(flush_i),
        .ready_o(nom_ready), .valid_o(nom_valid), .ALU_Operation_o(nom_op),
        .busy_o(nom_busy), .mdu_start_o(nom_mdu_start), .illegal_o(nom_illegal)
    );

    typedef struct packed {
        logic       v;
        logic [4:0] op;
        logic       ill;
        logic       ms;
    } exp_t;

    typedef struct {
        logic [6:0] f7;
        logic [2:0] cls;
        logic [2:0] f3;
        logic [4:0] op;
        logic       ill;
    } vec_t;

    exp_t sb_q[$];
    exp_t exp_cur = '0;
    exp_t got_e;
    logic acc_s = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Accept decision sampled mid-cycle, where inputs and ready_o are stable
    always @(negedge clk) begin
        acc_s = rst_n && ready_o;
        if (acc_s) sb_q.push_back(valid_i ? exp_cur : exp_t'(0));
    end

    always @(posedge clk) begin
        if (acc_s) begin
            #1;
            if (sb_q.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                got_e = sb_q.pop_front();
                check("sb_valid", valid_o, got_e.v);
                check("sb_mdu_start", mdu_start_o, got_e.ms);
                if (got_e.v) begin
                    check("sb_op", ALU_Operation_o, got_e.op);
                    check("sb_illegal", illegal_o, got_e.ill);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        valid_i = 1'b0;
        exp_cur = '0;
    endtask

    task automatic send(input logic [6:0] f7, input logic [2:0] cls, input logic [2:0] f3,
                        input logic [4:0] eop, input logic eill, input logic ems,
                        output int waited);
        valid_i  = 1'b1;
        funct7_i = f7;
        ALU_Op_i = cls;
        funct3_i = f3;
        exp_cur  = '{v: 1'b1, op: eop, ill: eill, ms: ems};
        waited   = 0;
        forever begin
            @(negedge clk);
            if (ready_o) break;
            waited++;
            if (waited >= 40) begin
                check("send_timeout", 1, 0);
                break;
            end
        end
        step();
    endtask

    vec_t vecs[] = '{
        '{7'b0100000, 3'b000, 3'b000, 5'd1,  1'b0},  // SUB
        '{7'b0000000, 3'b000, 3'b101, 5'd6,  1'b0},  // SRL
        '{7'b1010101, 3'b001, 3'b111, 5'd2,  1'b0},  // ANDI, funct7 ignored
        '{7'b0000000, 3'b010, 3'b000, 5'd7,  1'b0},  // LUI
        '{7'b0000000, 3'b011, 3'b001, 5'd9,  1'b0},  // BNE
        '{7'b0000000, 3'b100, 3'b010, 5'd0,  1'b0},  // SW
        '{7'b0100000, 3'b000, 3'b101, 5'd12, 1'b0},  // SRA
        '{7'b0000000, 3'b001, 3'b011, 5'd11, 1'b0},  // SLTIU
        '{7'b0000000, 3'b011, 3'b111, 5'd16, 1'b0},  // BGEU
        '{7'b0100000, 3'b001, 3'b101, 5'd12, 1'b0},  // SRAI
        '{7'b0000000, 3'b001, 3'b101, 5'd6,  1'b0},  // SRLI
        '{7'b0000000, 3'b000, 3'b010, 5'd10, 1'b0},  // SLT
        '{7'b0100000, 3'b001, 3'b001, 5'd0,  1'b1},  // SLLI with bad funct7
        '{7'b0000000, 3'b011, 3'b010, 5'd0,  1'b1},  // B funct3 010
        '{7'b0000000, 3'b111, 3'b000, 5'd0,  1'b1},  // class 111
        '{7'b0000000, 3'b110, 3'b000, 5'd0,  1'b0},  // AUIPC/JAL
        '{7'b0000000, 3'b101, 3'b010, 5'd0,  1'b0}   // load
    };

    initial begin
        int w, total_w, busy_n, ms_n, k;

        #3;
        check("rst_valid", valid_o, 0);
        check("rst_op", ALU_Operation_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_mdu_start", mdu_start_o, 0);
        check("rst_illegal", illegal_o, 0);
        check("rst_ready", ready_o, 1);
        stall_i = 1'b1;
        #1;
        check("rst_ready_stall", ready_o, 0);
        stall_i = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Decode table, driven back to back
        total_w = 0;
        foreach (vecs[i]) begin
            send(vecs[i].f7, vecs[i].cls, vecs[i].f3, vecs[i].op, vecs[i].ill, 1'b0, w);
            total_w += w;
        end
        idle();
        check("b2b_throughput_waits", total_w, 0);
        step();

        // DIV with a queued ADD behind it
        send(7'b0000001, 3'b000, 3'b100, 5'd21, 1'b0, 1'b1, w);
        valid_i  = 1'b1;
        funct7_i = 7'b0000000;
        ALU_Op_i = 3'b000;
        funct3_i = 3'b000;
        exp_cur  = '{v: 1'b1, op: 5'd0, ill: 1'b0, ms: 1'b0};
        busy_n = 0;
        ms_n   = 0;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mdu_start_o) ms_n++;
            if (ready_o) break;
            if (busy_o) busy_n++;
        end
        step();
        idle();
        check("div_busy_cycles", busy_n, 7);
        check("div_mdu_start_pulses", ms_n, 1);
        check("div_to_add_edges", k + 1, 8);
        step();

        // MUL encoding on both instances; the ENABLE_M=0 one must flag it
        send(7'b0000001, 3'b000, 3'b000, 5'd17, 1'b0, 1'b1, w);
        idle();
        check("nom_op", nom_op, 0);
        check("nom_illegal", nom_illegal, 1);
        check("nom_mdu_start", nom_mdu_start, 0);
        check("mul_busy", busy_o, 1);
        busy_n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (nom_busy) busy_n++;
        end
        check("nom_busy_never", busy_n, 0);
        step();

        // Flush on the 3rd BUSY cycle of a DIV
        send(7'b0000001, 3'b000, 3'b101, 5'd22, 1'b0, 1'b1, w);
        idle();
        step();
        step();
        check("flush_pre_busy", busy_o, 1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        #1;
        check("flush_valid", valid_o, 0);
        check("flush_busy", busy_o, 0);
        check("flush_ready", ready_o, 1);

        // Flush together with a valid op drops the op
        send(7'b0000000, 3'b000, 3'b110, 5'd3, 1'b0, 1'b0, w);
        valid_i  = 1'b1;
        funct3_i = 3'b000;
        flush_i  = 1'b1;
        #1;
        check("flush_in_ready", ready_o, 0);
        step();
        flush_i = 1'b0;
        idle();
        check("flush_in_dropped", valid_o, 0);
        step();

        // Stall with a pending ADD: outputs hold
        send(7'b0000000, 3'b000, 3'b100, 5'd4, 1'b0, 1'b0, w);
        stall_i  = 1'b1;
        funct3_i = 3'b000;
        exp_cur  = '{v: 1'b1, op: 5'd0, ill: 1'b0, ms: 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_ready", ready_o, 0);
            check("stall_valid_hold", valid_o, 1);
            check("stall_op_hold", ALU_Operation_o, 4);
        end
        step();
        stall_i = 1'b0;
        send(7'b0000000, 3'b000, 3'b000, 5'd0, 1'b0, 1'b0, w);
        idle();
        step();

        // Asynchronous reset in the middle of a MUL
        send(7'b0000001, 3'b000, 3'b011, 5'd20, 1'b0, 1'b1, w);
        idle();
        check("mul_pre_rst_busy", busy_o, 1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid", valid_o, 0);
        check("arst_op", ALU_Operation_o, 0);
        check("arst_busy", busy_o, 0);
        check("arst_mdu_start", mdu_start_o, 0);
        check("arst_illegal", illegal_o, 0);
        step();
        rst_n = 1'b1;
        step();
        step();

        check("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
